// File: rtl/rti_fsm_pkg.sv
// rti_fsm shared types and opcodes.
// State order follows the injected sequence.
`timescale 1ns/1ps
package rti_fsm_pkg;

  localparam logic [15:0] POP_PC_HIGH_OP = 16'b0110_0000_1000_1001;
  localparam logic [15:0] POP_PC_LOW_OP  = 16'b0110_0000_1000_1000;
  localparam logic [15:0] POP_CCR_OP     = 16'hFFFF;
  localparam logic [15:0] NOP_OP         = 16'h0000;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    POP_PC_HIGH = 3'd1,
    POP_PC_LOW  = 3'd2,
    POP_CCR     = 3'd3,
    NOP_1       = 3'd4,
    NOP_2       = 3'd5,
    NOP_3       = 3'd6,
    NOP_4       = 3'd7
  } rti_state_t;

  function automatic logic [15:0] state_op(
    input rti_state_t s
  );
    logic [15:0] op;
    op = POP_PC_HIGH_OP;
    unique case (1'b1)
      (s == POP_PC_LOW): op = POP_PC_LOW_OP;
      (s == POP_CCR):    op = POP_CCR_OP;
      (s == NOP_1),
      (s == NOP_2),
      (s == NOP_3),
      (s == NOP_4):      op = NOP_OP;
      default:           op = POP_PC_HIGH_OP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rti_fsm_if.sv
// RTI request and injected-instruction bundle.
// Master issues rti; slave drives out/stall.
`timescale 1ns/1ps
interface rti_fsm_if;
  logic        rti;
  logic [15:0] out;
  logic        stall;

  modport master (
    output rti,
    input  out,
    input  stall
  );

  modport slave (
    input  rti,
    output out,
    output stall
  );
endinterface

// File: rtl/rti_fsm.sv
// Return-from-interrupt sequencer.
// Injects pop PC hi/lo, pop CCR, 4 NOPs.
`timescale 1ns/1ps
module rti_fsm
  import rti_fsm_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  rti_fsm_if.slave  bus
);

  rti_state_t state;

  // Walk the fixed sequence; accept rti only in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:        state <= bus.rti ? POP_PC_HIGH
                                      : IDLE;
        POP_PC_HIGH: state <= POP_PC_LOW;
        POP_PC_LOW:  state <= POP_CCR;
        POP_CCR:     state <= NOP_1;
        NOP_1:       state <= NOP_2;
        NOP_2:       state <= NOP_3;
        NOP_3:       state <= NOP_4;
        NOP_4:       state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

  // Moore decode: outputs depend only on state.
  always_comb begin
    bus.out   = state_op(state);
    bus.stall = (state != IDLE);
  end

endmodule

// File: tb/tb_rti_fsm.sv
// Directed + random bench for rti_fsm.
// Reference model is a sequence-position counter.
`timescale 1ns/1ps
module tb_rti_fsm;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pos;

  rti_fsm_if bus();

  rti_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_out(input int p);
    logic [15:0] seq [0:7];
    seq[0] = 16'h6089; seq[1] = 16'h6089;
    seq[2] = 16'h6088; seq[3] = 16'hFFFF;
    seq[4] = 16'h0000; seq[5] = 16'h0000;
    seq[6] = 16'h0000; seq[7] = 16'h0000;
    return seq[p];
  endfunction

  task automatic chk(input string tag);
    logic [15:0] eo;
    logic        es;
    eo = exp_out(pos);
    es = (pos != 0);
    checks++;
    assert (bus.out === eo) else begin
      errors++;
      $error("FAIL %s out=%h exp=%h", tag, bus.out, eo);
    end
    checks++;
    assert (bus.stall === es) else begin
      errors++;
      $error("FAIL %s stall=%b exp=%b", tag, bus.stall, es);
    end
  endtask

  task automatic step(input logic r, input string tag);
    bus.rti = r;
    @(posedge clk);
    if (!reset) pos = 0;
    else if (pos == 0) pos = r ? 1 : 0;
    else pos = (pos == 7) ? 0 : pos + 1;
    #1;
    chk(tag);
    @(negedge clk);
  endtask

  initial begin
    int width;
    checks  = 0;
    errors  = 0;
    pos     = 0;
    reset   = 1'b0;
    bus.rti = 1'b0;

    repeat (2) @(posedge clk);
    #1 chk("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (4) step(1'b0, "idle_after_reset");

    step(1'b1, "single_start");
    repeat (9) step(1'b0, "single_seq");

    repeat (7) step(1'b1, "held_seq");
    step(1'b1, "held_idle");
    step(1'b1, "held_restart");
    repeat (7) step(1'b0, "held_drain");

    repeat (4) step(1'b0, "b2b_gap");
    step(1'b1, "b2b_start");
    repeat (7) step(1'b0, "b2b_seq");

    step(1'b1, "width_start");
    width = 1;
    for (int i = 0; i < 20 && bus.stall === 1'b1; i++) begin
      step(1'b0, "width_seq");
      if (bus.stall === 1'b1) width++;
    end
    checks++;
    assert (width == 7) else begin
      errors++;
      $error("FAIL stall_width got=%0d exp=7", width);
    end

    step(1'b1, "mid_start");
    step(1'b0, "mid_seq");
    step(1'b0, "mid_ccr");
    #2 reset = 1'b0;
    pos = 0;
    #1 chk("mid_reset_async");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step(1'b0, "mid_release");

    for (int i = 0; i < 300; i++)
      step(($urandom % 4) == 0, "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rti_fsm.md
Name: rti_fsm

Overview:
- Return-from-interrupt sequencer in the decode/fetch stage of the five-stage pipeline.
- On an RTI request it injects a fixed micro-op sequence into the instruction stream: pop PC high, pop PC low, pop CCR, then four NOP bubbles.
- It holds the pipeline stall high for the whole sequence.
- It is a Moore FSM; outputs depend only on the current state.

Parameters:
- POP_PC_HIGH_OP, 16'b0110_0000_1000_1001, instruction word that pops the upper PC half.
- POP_PC_LOW_OP, 16'b0110_0000_1000_1000, instruction word that pops the lower PC half.
- POP_CCR_OP, 16'hFFFF, instruction word that pops the CCR.
- NOP_OP, 16'h0000, bubble instruction word.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rti  in  1  RTI request; sampled on the rising edge in IDLE only.
- out  out  16  injected instruction word.
- stall  out  1  1 = hold fetch/PC while the sequence runs.

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-low. While `reset` is 0, the FSM goes to IDLE immediately, independent of `clk`.
- States (3-bit encoding, in sequence order): IDLE, POP_PC_HIGH, POP_PC_LOW, POP_CCR, NOP_1, NOP_2, NOP_3, NOP_4.
- Transitions, on the rising edge of `clk` while reset is deasserted:
  - IDLE -> POP_PC_HIGH if rti=1; otherwise stay in IDLE.
  - POP_PC_HIGH -> POP_PC_LOW -> POP_CCR -> NOP_1 -> NOP_2 -> NOP_3 -> NOP_4 -> IDLE, unconditionally.
- rti is ignored outside IDLE. A new request can only be accepted from IDLE, on the edge after NOP_4 has completed.
- Outputs by state:
  - IDLE: out=POP_PC_HIGH_OP, stall=0 (this is also the reset value of both outputs).
  - POP_PC_HIGH: out=POP_PC_HIGH_OP, stall=1.
  - POP_PC_LOW: out=POP_PC_LOW_OP, stall=1.
  - POP_CCR: out=POP_CCR_OP, stall=1.
  - NOP_1..NOP_4: out=16'h0000, stall=1.
- Latency: rti high at edge N gives stall=1 and out=POP_PC_HIGH_OP after edge N. stall stays 1 for exactly 7 cycles and returns to 0 after edge N+7.
- rti held high across the whole sequence has no effect. If it is still high in IDLE after edge N+7, a new sequence starts at edge N+8.
- Reset mid-sequence aborts immediately: state=IDLE, stall=0, out=POP_PC_HIGH_OP.
- Unused/illegal state encodings return to IDLE on the next edge, with outputs equal to the IDLE outputs.
- Outputs are decoded combinationally from the state register; there is no combinational path from rti to any output.

Decomposition:
- Shared package (e.g. `cpu_pkg`) holds:
  - the state enumeration;
  - the opcode constants POP_PC_HIGH_OP, POP_PC_LOW_OP, POP_CCR_OP and NOP_OP, which are shared with the decoder.
- No sub-module: one state register plus next-state and output decode.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> out=16'h6089, stall=0. Release reset with rti=0 for 4 cycles -> unchanged.
- Single request: pulse rti=1 for one edge. Sample after each subsequent edge:
  - 16'h6089/stall 1, then 16'h6088/1, then 16'hFFFF/1;
  - then 16'h0000/1 four times;
  - then 16'h6089/0 and held while rti=0.
- Held request: rti=1 for the whole sequence -> same 7-cycle sequence, ignored mid-sequence. A restart to 16'h6089/stall 1 occurs one edge after returning to IDLE.
- Back-to-back: issue a second rti pulse 4 idle cycles after the first sequence ends -> identical 7-cycle sequence repeats.
- Reset mid-sequence: assert reset=0 while in POP_CCR -> out=16'h6089 and stall=0 immediately, without waiting for a clock edge. After release with rti=0 -> remains IDLE.
- Stall width: count stall=1 cycles per request -> exactly 7.
